// File: rtl/serial_comp_pkg.sv
// serial_comp_pkg
// Shared definitions for the serial magnitude comparator.
//   state_e    : controller state encoding (IDLE, CMP, DONE)
//   DEF_WIDTH  : default operand width in bits
//   PAIRS_W    : width of the pairs-examined counter output
package serial_comp_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int PAIRS_W   = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/serial_comp_ctrl_if.sv
// serial_comp_ctrl_if
// Request/result bundle between a requester and the serial comparator.
//   start        : request to compare a and b (requester -> comparator)
//   a, b         : unsigned operands, WIDTH bits (requester -> comparator)
//   busy         : comparison in progress or reporting (comparator -> requester)
//   done         : one-cycle result-valid pulse (comparator -> requester)
//   L, E, M      : a<b, a==b, a>b flags of the last result
//   pairs        : number of 2-bit pairs examined for the last result
// Modports: master = requester side, slave = comparator side.
interface serial_comp_ctrl_if
  import serial_comp_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);

  logic               start;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               busy;
  logic               done;
  logic               L;
  logic               E;
  logic               M;
  logic [PAIRS_W-1:0] pairs;

  modport master (
    output start, a, b,
    input  busy, done, L, E, M, pairs
  );

  modport slave (
    input  start, a, b,
    output busy, done, L, E, M, pairs
  );

endinterface

// File: rtl/comp2_slice.sv
// comp2_slice
// Combinational unsigned compare of two 2-bit values.
//   x_i, y_i : 2-bit operands
//   lt_o     : x < y
//   eq_o     : x == y
//   gt_o     : x > y
// Exactly one of lt_o/eq_o/gt_o is high for any known input.
module comp2_slice (
  input  logic [1:0] x_i,
  input  logic [1:0] y_i,
  output logic       lt_o,
  output logic       eq_o,
  output logic       gt_o
);

  assign lt_o = (x_i <  y_i);
  assign eq_o = (x_i == y_i);
  assign gt_o = (x_i >  y_i);

endmodule

// File: rtl/serial_comp_ctrl.sv
// serial_comp_ctrl
// Serial magnitude comparator: compares two unsigned WIDTH-bit operands one
// 2-bit pair per cycle, most significant pair first, stopping at the first
// pair that differs.
//   clk   : clock, all state on the rising edge
//   rst_n : asynchronous active-low reset
//   bus   : serial_comp_ctrl_if.slave (start/a/b in; busy/done/L/E/M/pairs out)
// Parameter WIDTH must be even, 2..32.
module serial_comp_ctrl
  import serial_comp_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  serial_comp_ctrl_if.slave  bus
);

  localparam int HALF  = WIDTH / 2;
  localparam int IDX_W = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(HALF - 1);
  localparam logic [PAIRS_W-1:0] HALF_CNT = PAIRS_W'(HALF);

  generate
    if ((WIDTH % 2) != 0 || WIDTH < 2 || WIDTH > 32) begin : g_bad_width
      $error("serial_comp_ctrl: WIDTH must be even and within 2..32");
    end
  endgenerate

  state_e             state_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [IDX_W-1:0]   idx_q;
  logic               busy_q;
  logic               done_q;
  logic               l_q;
  logic               e_q;
  logic               m_q;
  logic [PAIRS_W-1:0] pairs_q;

  logic [1:0]         pair_a;
  logic [1:0]         pair_b;
  logic               s_lt;
  logic               s_eq;
  logic               s_gt;
  logic [PAIRS_W-1:0] pairs_d;

  // Select pair idx_q (bits [2i+1:2i]) of each captured operand.
  assign pair_a = 2'(a_q >> {idx_q, 1'b0});
  assign pair_b = 2'(b_q >> {idx_q, 1'b0});

  // Pairs examined so far, counting the one being evaluated this cycle.
  assign pairs_d = HALF_CNT - PAIRS_W'(idx_q);

  comp2_slice u_slice (
    .x_i  (pair_a),
    .y_i  (pair_b),
    .lt_o (s_lt),
    .eq_o (s_eq),
    .gt_o (s_gt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      l_q     <= 1'b0;
      e_q     <= 1'b0;
      m_q     <= 1'b0;
      pairs_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            a_q     <= bus.a;
            b_q     <= bus.b;
            idx_q   <= LAST_IDX;
            state_q <= CMP;
            busy_q  <= 1'b1;
          end
        end
        CMP: begin
          if (s_eq && (idx_q != '0)) begin
            idx_q <= idx_q - 1'b1;
          end else begin
            // Either a differing pair (early exit) or equal down to pair 0.
            l_q     <= s_lt;
            e_q     <= s_eq;
            m_q     <= s_gt;
            pairs_q <= pairs_d;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.L     = l_q;
  assign bus.E     = e_q;
  assign bus.M     = m_q;
  assign bus.pairs = pairs_q;

endmodule

// File: doc/serial_comp_ctrl.md
SERIAL_COMP_CTRL -- requirements
Module: serial_comp_ctrl

Interface
REQ-001 Parameter: WIDTH, default 8, operand width in bits; SHALL be even, 2..32.
REQ-002 Port: clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 Port: start  input  1  request to compare a and b.
REQ-005 Port: a  input  WIDTH  operand A, unsigned.
REQ-006 Port: b  input  WIDTH  operand B, unsigned.
REQ-007 Port: busy  output  1  high while a comparison is in progress or reporting.
REQ-008 Port: done  output  1  one-cycle pulse marking a valid result.
REQ-009 Port: L  output  1  A less than B.
REQ-010 Port: E  output  1  A equal to B.
REQ-011 Port: M  output  1  A greater than B.
REQ-012 Port: pairs  output  5  count of 2-bit pairs examined for the last result.

Function
REQ-013 The FSM SHALL have states IDLE, CMP and DONE.
REQ-014 In IDLE, start=1 at a clock edge SHALL capture a and b into internal registers, load pair index to WIDTH/2-1, and move to CMP.
REQ-015 start SHALL be ignored in CMP and DONE, and captured operands SHALL NOT change until the next accepted start.
REQ-016 In CMP, each cycle SHALL evaluate exactly one 2-bit pair, bits [2i+1:2i] at index i, MSB pair first, using the comparator slice.
REQ-017 A slice result of less or greater SHALL end the comparison: at that edge L/M register the slice result, E=0, and the state moves to DONE (early termination).
REQ-018 A slice result of equal at index 0 SHALL end the comparison with E=1, L=0, M=0, moving to DONE.
REQ-019 A slice result of equal at index >0 SHALL decrement the index and remain in CMP.
REQ-020 Latency: done SHALL rise k cycles after the start-sampling edge, where k = pairs examined (1..WIDTH/2).
REQ-021 done SHALL equal (state==DONE), registered, high for exactly one cycle; DONE SHALL always return to IDLE at the next edge.
REQ-022 busy SHALL be high exactly when the state is CMP or DONE.
REQ-023 L, E, M and pairs SHALL update only on the edge entering DONE and hold until the next result.
REQ-024 Exactly one of L/E/M SHALL be high after the first result; none SHALL be high before it.
REQ-025 start held high continuously SHALL yield back-to-back comparisons, one accepted per return to IDLE (minimum period k+2 cycles).

Reset
REQ-026 rst_n=0 SHALL immediately force IDLE, busy=0, done=0, L=E=M=0, pairs=0, index and operand registers 0, regardless of clk.
REQ-027 Reset asserted mid-comparison SHALL abort it without a done pulse; after release the block SHALL accept a new start on the first edge.

Structure
REQ-028 Shared package serial_comp_pkg SHALL hold the state encoding constants (IDLE, CMP, DONE) and the default WIDTH.
REQ-029 One combinational sub-module comp2_slice SHALL compare two 2-bit values and output lt/eq/gt, one-hot; serial_comp_ctrl SHALL instantiate it once.

Verification
REQ-030 WIDTH=8: a=0x80, b=0x7F, start 1 cycle -> done after 1 cycle, M=1, L=E=0, pairs=1.
REQ-031 WIDTH=8: a=0x12, b=0x13 -> done after 4 cycles, L=1, pairs=4; a=0xA5, b=0xA5 -> E=1, pairs=4.
REQ-032 start pulsed during CMP with different a/b -> ignored; result reflects the originally captured operands.
REQ-033 rst_n low for 1 cycle during the 2nd CMP cycle of a=0x00, b=0x01 -> no done pulse, all outputs 0; next start compares correctly.
REQ-034 start held high, operands alternating 0x03/0x02 vs 0x02/0x03 -> done pulses every 6 cycles, M then L, busy low one cycle between.
REQ-035 Exhaustive WIDTH=2 sweep of all 16 a/b pairs -> L/E/M match unsigned compare, done 1 cycle after each start.
